// File: rtl/int_arbiter.sv
// Interrupt arbiter: latches request edges, selects a preempting source, runs the
// ID-stage request/ack handshake and tracks nested in-service levels until uret.
module int_arbiter #(
   parameter int               WIDTH   = 32,
   parameter logic [WIDTH-1:0] VEC0    = 'h000030AC,
   parameter logic [WIDTH-1:0] VEC1    = 'h00003170,
   parameter logic [WIDTH-1:0] VEC2    = 'h00003234,
   parameter int               HOLDOFF = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       IRQ,
   input  logic             IE,
   input  logic             int_ack,
   input  logic             uret,
   output logic             int_req,
   output logic [2:0]       int_id,
   output logic [WIDTH-1:0] int_vec,
   output logic [2:0]       IRW,
   output logic [2:0]       IRS,
   output logic [1:0]       depth
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

   localparam logic [2:0] LP_HOLD = 3'(HOLDOFF);

   state_t     r_state, w_state_nxt;
   logic [2:0] r_irq_d, r_pend, r_ip, r_id, r_cnt;
   logic [2:0] w_edge, w_irs, w_above, w_cand;
   logic [2:0] w_ip_nxt, w_pend_nxt, w_id_nxt, w_cnt_nxt;
   logic       w_accept, w_uret_eff;

   function automatic logic [2:0] hi_bit(input logic [2:0] v);
      if (v[2])      return 3'b100;
      else if (v[1]) return 3'b010;
      else if (v[0]) return 3'b001;
      else           return 3'b000;
   endfunction

   always_comb begin
      w_edge     = IRQ & ~r_irq_d;
      w_irs      = hi_bit(r_ip);
      case (w_irs)
         3'b100:  w_above = 3'b000;
         3'b010:  w_above = 3'b100;
         3'b001:  w_above = 3'b110;
         default: w_above = 3'b111;
      endcase
      w_cand     = hi_bit(r_pend & w_above);
      w_uret_eff = uret && (r_ip != 3'b000);
      w_accept   = (r_state == S_REQ) && int_ack;
      // uret retires the old top level before an accept in the same cycle pushes a new one
      w_ip_nxt   = w_uret_eff ? (r_ip & ~w_irs) : r_ip;
      if (w_accept) w_ip_nxt = w_ip_nxt | r_id;
      w_pend_nxt = (r_pend & ~(w_accept ? r_id : 3'b000)) | w_edge;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_id_nxt    = r_id;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_uret_eff) begin
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = LP_HOLD;
            end else if (IE && (w_cand != 3'b000)) begin
               w_state_nxt = S_REQ;
               w_id_nxt    = w_cand;
            end
         end
         S_REQ: begin
            if (w_accept) begin
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = LP_HOLD;
            end else if (!IE) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_HOLD: begin
            if (w_uret_eff) begin
               w_cnt_nxt = LP_HOLD;
            end else if (r_cnt <= 3'd1) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = 3'd0;
            end else begin
               w_cnt_nxt = r_cnt - 3'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_irq_d <= 3'b000;
         r_pend  <= 3'b000;
         r_ip    <= 3'b000;
         r_id    <= 3'b000;
         r_cnt   <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_irq_d <= IRQ;
         r_pend  <= w_pend_nxt;
         r_ip    <= w_ip_nxt;
         r_id    <= w_id_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      int_req = (r_state == S_REQ);
      int_id  = int_req ? r_id : 3'b000;
      case (int_id)
         3'b001:  int_vec = VEC0;
         3'b010:  int_vec = VEC1;
         3'b100:  int_vec = VEC2;
         default: int_vec = '0;
      endcase
      IRW   = r_pend;
      IRS   = w_irs;
      depth = 2'(r_ip[0]) + 2'(r_ip[1]) + 2'(r_ip[2]);
   end

endmodule

// File: tb/tb_int_arbiter.sv
// Directed bench for int_arbiter: expected grants are queued when requests are
// raised and popped when int_req is observed; status outputs are checked inline.
module tb_int_arbiter;

   localparam logic [31:0] E_VEC0 = 32'h000030AC;
   localparam logic [31:0] E_VEC1 = 32'h00003170;
   localparam logic [31:0] E_VEC2 = 32'h00003234;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  IRQ;
   logic        IE, int_ack, uret;
   logic        int_req;
   logic [2:0]  int_id;
   logic [31:0] int_vec;
   logic [2:0]  IRW, IRS;
   logic [1:0]  depth;

   int n_checks = 0;
   int n_pass   = 0;
   logic [2:0] sb[$];

   int_arbiter #(.WIDTH(32), .HOLDOFF(3)) dut (
      .clk(clk), .rst(rst), .IRQ(IRQ), .IE(IE), .int_ack(int_ack), .uret(uret),
      .int_req(int_req), .int_id(int_id), .int_vec(int_vec),
      .IRW(IRW), .IRS(IRS), .depth(depth)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] exp_vec(input logic [2:0] id);
      case (id)
         3'b001:  return E_VEC0;
         3'b010:  return E_VEC1;
         3'b100:  return E_VEC2;
         default: return 32'h0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_grant(input string tag);
      logic [2:0] e;
      chk({tag, "_req"}, {31'b0, int_req}, 32'd1);
      n_checks++;
      assert (sb.size() != 0) n_pass++;
      else $error("FAIL %s_sb: observed grant %0h expected no grant", tag, int_id);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_id"}, {29'b0, int_id}, {29'b0, e});
         chk({tag, "_vec"}, int_vec, exp_vec(e));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; IRQ = 3'b000; IE = 1'b0; int_ack = 1'b0; uret = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_req", {31'b0, int_req}, 32'd0);
      chk("rst_id", {29'b0, int_id}, 32'd0);
      chk("rst_vec", int_vec, 32'd0);
      chk("rst_irw", {29'b0, IRW}, 32'd0);
      chk("rst_irs", {29'b0, IRS}, 32'd0);
      chk("rst_depth", {30'b0, depth}, 32'd0);
      IE = 1'b1;

      // single source
      IRQ = 3'b001; tick();
      chk("single_irw", {29'b0, IRW}, 32'h1);
      chk("single_noreq_yet", {31'b0, int_req}, 32'd0);
      IRQ = 3'b000; sb.push_back(3'b001); tick();
      check_grant("single");
      tick();
      chk("single_req_held", {31'b0, int_req}, 32'd1);
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      chk("single_irs", {29'b0, IRS}, 32'h1);
      chk("single_depth", {30'b0, depth}, 32'd1);
      chk("single_irw_clr", {29'b0, IRW}, 32'h0);
      chk("single_req_low", {31'b0, int_req}, 32'd0);
      repeat (3) tick();
      chk("single_holdoff", {31'b0, int_req}, 32'd0);

      // nesting
      IRQ = 3'b100; tick(); IRQ = 3'b000; sb.push_back(3'b100); tick();
      check_grant("nest");
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      chk("nest_depth2", {30'b0, depth}, 32'd2);
      chk("nest_irs100", {29'b0, IRS}, 32'h4);
      uret = 1'b1; tick(); uret = 1'b0;
      chk("nest_uret1_irs", {29'b0, IRS}, 32'h1);
      chk("nest_uret1_depth", {30'b0, depth}, 32'd1);
      repeat (3) tick();
      uret = 1'b1; tick(); uret = 1'b0;
      chk("nest_uret2_irs", {29'b0, IRS}, 32'h0);
      chk("nest_uret2_depth", {30'b0, depth}, 32'd0);
      repeat (3) tick();

      // blocking by an equal/higher in-service level
      IRQ = 3'b010; tick(); IRQ = 3'b000; sb.push_back(3'b010); tick();
      check_grant("blk_setup");
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      chk("blk_irs", {29'b0, IRS}, 32'h2);
      repeat (3) tick();
      IRQ = 3'b001; tick(); IRQ = 3'b000;
      chk("blk_irw", {29'b0, IRW}, 32'h1);
      repeat (4) tick();
      chk("blk_noreq", {31'b0, int_req}, 32'd0);
      chk("blk_irw_kept", {29'b0, IRW}, 32'h1);
      uret = 1'b1; tick(); uret = 1'b0;
      chk("blk_uret_irs", {29'b0, IRS}, 32'h0);
      sb.push_back(3'b001);
      repeat (3) tick();
      chk("blk_hold_noreq", {31'b0, int_req}, 32'd0);
      tick();
      check_grant("blk_release");

      // freeze: higher edge while requesting does not change int_id
      IRQ = 3'b100; tick(); IRQ = 3'b000;
      chk("frz_irw", {29'b0, IRW}, 32'h5);
      chk("frz_id1", {29'b0, int_id}, 32'h1);
      tick();
      chk("frz_id2", {29'b0, int_id}, 32'h1);
      sb.push_back(3'b100);
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      chk("frz_irs", {29'b0, IRS}, 32'h1);
      chk("frz_irw_after", {29'b0, IRW}, 32'h4);
      repeat (3) tick();
      chk("frz_hold_noreq", {31'b0, int_req}, 32'd0);
      tick();
      check_grant("frz_next");

      // uret with ack at IP=001, int_id=100
      uret = 1'b1; int_ack = 1'b1; tick(); uret = 1'b0; int_ack = 1'b0;
      chk("ua1_irs", {29'b0, IRS}, 32'h4);
      chk("ua1_depth", {30'b0, depth}, 32'd1);
      uret = 1'b1; tick(); uret = 1'b0;
      chk("ua1_clear", {29'b0, IRS}, 32'h0);
      repeat (3) tick();

      // withdraw on IE=0
      IRQ = 3'b010; tick(); IRQ = 3'b000; sb.push_back(3'b010); tick();
      check_grant("wd");
      IE = 1'b0; tick();
      chk("wd_req_low", {31'b0, int_req}, 32'd0);
      chk("wd_irw_kept", {29'b0, IRW}, 32'h2);
      tick();
      chk("wd_stay_low", {31'b0, int_req}, 32'd0);
      IE = 1'b1; sb.push_back(3'b010); tick();
      check_grant("wd_rereq");

      // new edge on the source being accepted keeps it pending
      IRQ = 3'b010; int_ack = 1'b1; tick(); IRQ = 3'b000; int_ack = 1'b0;
      chk("same_irw", {29'b0, IRW}, 32'h2);
      chk("same_irs", {29'b0, IRS}, 32'h2);
      repeat (4) tick();
      chk("same_blocked", {31'b0, int_req}, 32'd0);

      // uret with ack at IP=010, int_id=100
      IRQ = 3'b100; tick(); IRQ = 3'b000; sb.push_back(3'b100); tick();
      check_grant("ua2");
      uret = 1'b1; int_ack = 1'b1; tick(); uret = 1'b0; int_ack = 1'b0;
      chk("ua2_irs", {29'b0, IRS}, 32'h4);
      chk("ua2_depth", {30'b0, depth}, 32'd1);
      chk("ua2_irw", {29'b0, IRW}, 32'h2);
      uret = 1'b1; tick(); uret = 1'b0;
      chk("ua2_clear", {29'b0, IRS}, 32'h0);
      sb.push_back(3'b010);
      repeat (4) tick();
      check_grant("ua2_pend");
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      uret = 1'b1; tick(); uret = 1'b0;
      repeat (3) tick();

      // uret with nothing in service is ignored
      uret = 1'b1; IRQ = 3'b001; tick(); uret = 1'b0; IRQ = 3'b000;
      chk("uret0_irw", {29'b0, IRW}, 32'h1);
      chk("uret0_depth", {30'b0, depth}, 32'd0);
      sb.push_back(3'b001); tick();
      check_grant("uret0");

      // asynchronous reset mid-request, IRQ held high across release
      #2; rst = 1'b1; IRQ = 3'b001; #1;
      chk("arst_req", {31'b0, int_req}, 32'd0);
      chk("arst_id", {29'b0, int_id}, 32'd0);
      chk("arst_vec", int_vec, 32'd0);
      chk("arst_irw", {29'b0, IRW}, 32'h0);
      chk("arst_depth", {30'b0, depth}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("arst_first_edge", {29'b0, IRW}, 32'h1);
      IRQ = 3'b000;

      chk("sb_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/int_arbiter.md
# int_arbiter

Interrupt arbiter for the pipelined CPU. It latches rising edges on the three external request lines and selects the highest-priority pending source that may preempt the current in-service level. It presents that source to the ID stage through a request/acknowledge handshake and tracks nested in-service levels until the matching `uret` retires in WB. It replaces the separate request-latch, in-service and pending bookkeeping with one sequenced block and enforces a hold-off window while the pipeline commits the CSR side effects.

## Interface
- `WIDTH`, 32, width of the handler vector output
- `VEC0`, 'h000030AC, handler address for source 0 (lowest priority)
- `VEC1`, 'h00003170, handler address for source 1
- `VEC2`, 'h00003234, handler address for source 2 (highest priority)
- `HOLDOFF`, 3, cycles after an accept or a `uret` during which no new request is raised (1..7)
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `IRQ`  in  3  raw request lines, already synchronous to `clk`; bit 2 is highest priority
- `IE`  in  1  global interrupt enable (CSR 0x004 value)
- `int_ack`  in  1  ID stage has committed the implicit interrupt instruction for `int_id`
- `uret`  in  1  one-cycle pulse: `uret` retiring in WB
- `int_req`  out  1  request to inject an interrupt entry
- `int_id`  out  3  one-hot source being requested; 0 when `int_req`=0
- `int_vec`  out  WIDTH  handler address for `int_id`; 0 when `int_req`=0
- `IRW`  out  3  pending bits (latched, not yet accepted), for LED display
- `IRS`  out  3  one-hot highest in-service level; 0 when none
- `depth`  out  2  number of in-service levels (0..3)

## Operation
- Edge detect: `irq_d` registers `IRQ`; an edge is `IRQ & ~irq_d`. An edge sets the matching pending bit. A level held high produces exactly one edge.
- Pending bit clears when its source is accepted (`int_ack` in REQ with `int_id` = that bit). If a new edge on the same source arrives in the same cycle, set wins and the bit stays pending.
- The in-service mask `IP` has 3 bits. `IRS` is the highest set bit of `IP`.
- Candidate selection: the highest pending bit strictly higher in priority than `IRS`. Any pending bit qualifies when `IP`=0. Equal or lower priorities wait.
- FSM states:
  - IDLE: if `IE`=1 and a candidate exists, go to REQ and latch the candidate into `int_id`.
  - REQ: `int_req`=1; `int_id` and `int_vec` stay frozen even if a higher-priority edge arrives.
    - `int_ack`=1: set `IP[int_id]`, clear that pending bit, go to HOLD.
    - `IE`=0 without ack: drop the request and go to IDLE. The pending bit is kept.
  - HOLD: count down `HOLDOFF` cycles with `int_req`=0, then go to IDLE.
- `uret`: clears the highest set bit of `IP`, evaluated on pre-edge `IP`. From IDLE or HOLD, it (re)loads the HOLD counter with `HOLDOFF`. In REQ, only `IP` updates, and `int_id` stays frozen even if `uret` lowers `IRS`.
- `uret` with `IP`=0 is ignored: no state change.
- `uret` and `int_ack` in the same cycle: clear the old highest bit first, then set `IP[int_id]`, then enter HOLD.
- `int_ack` outside REQ is ignored.
- `depth` is the popcount of `IP`.
- `int_vec` is selected from `VEC0..2` by the registered `int_id`.

## Timing
- Reset values: `int_req`=0, `int_id`=0, `int_vec`=0, `IRW`=0, `IRS`=0, `depth`=0, `IP`=0, `irq_d`=0, state IDLE, hold counter 0.
- An `IRQ` line already high when reset releases counts as an edge on the first clock.
- Latency from `IRQ` rising before edge k:
  - pending visible on `IRW` after edge k.
  - `int_req` high after edge k+1, if IDLE and `IE`=1.
- `int_req` remains high until the edge that samples `int_ack`=1 or `IE`=0; it is low the following cycle.
- After ack at edge a: `IP`, `IRS` and `depth` update at edge a; `int_req` is low for cycles a..a+HOLDOFF. The earliest re-request is high after edge a+HOLDOFF+1.
- Reset asserted mid-handshake clears all state immediately; `int_req` falls without waiting for `clk`.

## Test plan
- Single source: `IE`=1, pulse `IRQ`=001 at edge 1 → `IRW`=001 after edge 1, `int_req`=1, `int_id`=001, `int_vec`='h30AC after edge 2. `int_ack` at edge 4 → `IRS`=001, `depth`=1, `IRW`=000, `int_req` low through edge 7.
- Nesting: with `IRS`=001 after HOLD, raise `IRQ[2]` → request with `int_vec`='h3234, ack → `depth`=2, `IRS`=100. `uret` → `IRS`=001, `depth`=1. Second `uret` → `IRS`=0.
- Blocking: with `IRS`=010, raise `IRQ[0]` → no `int_req`, `IRW`=001 retained. `uret` → after HOLDOFF, `int_req` with `int_id`=001.
- Freeze and withdraw: in REQ for `int_id`=001, raise `IRQ[2]` → `int_id` stays 001 until ack, then 100 is requested after hold. A separate run drops `IE` in REQ → `int_req`=0 next cycle, `IRW` bit kept, re-request when `IE`=1.
- Corner cases:
  - `IRQ[1]` edge in the same cycle as ack of source 1 → `IRW[1]` stays 1.
  - `uret` with `IP`=0 → no change.
  - `uret` and ack together at `IP`=010 with `int_id`=100 → `IP`=100.
  - `rst` pulse mid-REQ → all outputs 0 asynchronously.
